// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow with start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             borrowOut,
  output logic             overflow
`else
  output logic             borrowOut
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bo_q, bo_d;
  logic d_bit, br_nx, last, accept;
  assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign accept = start && state_q != RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ov_q, ov_d;
  always_comb begin
    ov_d = ov_q;
    if (!accept && state_q == RUN && last)
      ov_d = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) ov_q <= 1'b0;
    else ov_q <= ov_d;
  assign overflow = ov_q;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    bo_d    = bo_q;
    if (accept) begin
      state_d = RUN;
      a_d     = in1;
      b_d     = in2;
      br_d    = borrowIn;
      cnt_d   = '0;
      r_d     = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_nx;
      r_d   = {d_bit, r_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        out_d   = {d_bit, r_q[WIDTH-1:1]};
        bo_d    = br_nx;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      bo_q    <= bo_d;
    end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign out       = out_q;
  assign borrowOut = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table, hand-written sequences and random ops checked against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 16;
  logic clk, resetN, start, borrowIn, busy, done, borrowOut, overflow;
  logic [W-1:0] in1, in2, out;
  int errors = 0, checks = 0;
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .resetN(resetN), .start(start), .in1(in1), .in2(in2), .borrowIn(borrowIn),
    .busy(busy), .done(done), .out(out),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .borrowOut(borrowOut), .overflow(overflow)
`else
    .borrowOut(borrowOut)
`endif
  );
`ifndef SERIAL_SUB_OVERFLOW_EN
  assign overflow = 1'b0;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] eo;
    logic         ebo, eov;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model(input logic [W-1:0] a, b, input logic bi,
                       output logic [W-1:0] eo, output logic ebo, output logic eov);
    int s;
    eo  = W'(int'(a) - int'(b) - int'(bi));
    ebo = int'(a) < int'(b) + int'(bi);
    s   = int'($signed(a)) - int'($signed(b)) - int'(bi);
    eov = s < -(1 << (W - 1)) || s > (1 << (W - 1)) - 1;
  endtask
  task automatic start_op(input logic [W-1:0] a, b, input logic bi);
    @(negedge clk);
    in1 = a; in2 = b; borrowIn = bi; start = 1'b1;
  endtask
  task automatic track(input string nm, input logic [W-1:0] eo, input logic ebo, input logic eov,
                       input logic [W-1:0] prev, input bit hold, input logic [W-1:0] na, nb,
                       input logic nbi, input int pulse_k);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " busy@E0"}, busy, 1);
    chk({nm, " done@E0"}, done, 0);
    chk({nm, " out held@E0"}, out, prev);
    if (hold) begin
      in1 = na; in2 = nb; borrowIn = nbi;
    end else start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < W) begin
        chk({nm, " busy run"}, busy, 1);
        chk({nm, " done run"}, done, 0);
        chk({nm, " out held run"}, out, prev);
      end else begin
        chk({nm, " busy end"}, busy, 0);
        chk({nm, " done end"}, done, 1);
        chk({nm, " out"}, out, eo);
        chk({nm, " borrowOut"}, borrowOut, ebo);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({nm, " overflow"}, overflow, eov);
`endif
      end
      if (pulse_k != 0 && k == pulse_k) begin
        start = 1'b1; in1 = 16'h5555; in2 = 16'haaaa;
      end
      if (pulse_k != 0 && k == pulse_k + 1) start = 1'b0;
    end
  endtask
  task automatic idle_after(input string nm, input logic [W-1:0] eo);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " done one cycle"}, done, 0);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " out kept"}, out, eo);
  endtask
  vec_t tbl[6];
  logic [W-1:0] ra, rb, eo, prev;
  logic rbi, ebo, eov;
  initial begin
    tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h0003, 16'h0005, 1'b0, 16'hfffe, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'hffff, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7fff, 1'b0, 1'b1};
    tbl[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{16'hffff, 16'h0000, 1'b1, 16'hfffe, 1'b0, 1'b0};
    resetN = 1'b0; start = 1'b0; in1 = '0; in2 = '0; borrowIn = 1'b0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out", out, 0);
    chk("reset borrowOut", borrowOut, 0);
    chk("reset overflow", overflow, 0);
    @(negedge clk);
    resetN = 1'b1;
    prev = '0;
    foreach (tbl[i]) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].bi);
      track($sformatf("tbl%0d", i), tbl[i].eo, tbl[i].ebo, tbl[i].eov, prev, 1'b0, '0, '0, 1'b0, 0);
      idle_after($sformatf("tbl%0d", i), tbl[i].eo);
      prev = tbl[i].eo;
    end
    start_op(16'h00ff, 16'h0001, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort out", out, 0);
    chk("abort borrowOut", borrowOut, 0);
    chk("abort done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort no done", done, 0);
    end
    resetN = 1'b1;
    start_op(16'h0002, 16'h0001, 1'b0);
    track("post reset", 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, '0, '0, 1'b0, 0);
    idle_after("post reset", 16'h0001);
    start_op(16'h1234, 16'h0234, 1'b0);
    track("b2b first", 16'h1000, 1'b0, 1'b0, 16'h0001, 1'b1, 16'hffff, 16'hffff, 1'b0, 0);
    track("b2b second", 16'h0000, 1'b0, 1'b0, 16'h1000, 1'b0, '0, '0, 1'b0, 4);
    idle_after("b2b second", 16'h0000);
    prev = '0;
    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      if (n == 0) begin ra = 16'h7fff; rb = 16'hffff; rbi = 1'b1; end
      if (n == 1) begin ra = 16'h8000; rb = 16'h0000; rbi = 1'b1; end
      model(ra, rb, rbi, eo, ebo, eov);
      start_op(ra, rb, rbi);
      track($sformatf("rnd%0d", n), eo, ebo, eov, prev, 1'b0, '0, '0, 1'b0, 0);
      prev = eo;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
